// File: rtl/rf_wport_arb.sv
// Register-file write-port arbiter: shares one write port between the WB stage and a
// buffered multi-cycle unit, with read-hazard flags and a starvation-driven WB stall.
module rf_wport_arb #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Wb_we,
    input  logic [4:0]  Wb_rw,
    input  logic [31:0] Wb_data,
    input  logic        Md_valid,
    output logic        Md_ready,
    input  logic [4:0]  Md_rw,
    input  logic [31:0] Md_data,
    output logic        WrEn,
    output logic [4:0]  Rw,
    output logic [31:0] busW,
    output logic        Stall_wb,
    input  logic [4:0]  Ra,
    input  logic [4:0]  Rb,
    output logic        Hazard_A,
    output logic        Hazard_B
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]       rw_q   [DEPTH];
    logic [4:0]       rw_d   [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;
    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [3:0]       starve_q, starve_d;
    logic             rdy_q, rdy_d;

    logic full, nonempty, starve, wb_req, push, push_e, pop, wb_grant;
    logic haz_a, haz_b;

    assign full     = (count_q == CW'(DEPTH));
    assign nonempty = (count_q != '0);
    assign starve   = nonempty && (starve_q == 4'(STARVE_LIMIT));
    assign wb_req   = Wb_we && (Wb_rw != 5'd0);
    // rdy_q keeps the MD side closed until the first clock edge after reset release.
    assign Md_ready = rdy_q && !full;
    assign push     = Md_valid && Md_ready;
    assign push_e   = push && (Md_rw != 5'd0);

    always_comb begin
        WrEn     = 1'b0;
        Rw       = 5'd0;
        busW     = 32'd0;
        Stall_wb = 1'b0;
        pop      = 1'b0;
        wb_grant = 1'b0;
        starve_d = 4'd0;
        if (Rst_n) begin
            if (starve) begin
                Stall_wb = 1'b1;
                pop      = 1'b1;
            end else if (wb_req) begin
                wb_grant = 1'b1;
                WrEn     = 1'b1;
                Rw       = Wb_rw;
                busW     = Wb_data;
                starve_d = nonempty ? starve_q + 4'd1 : 4'd0;
            end else if (nonempty) begin
                pop = 1'b1;
            end
            // Entries superseded by a later WB write leave the FIFO silently.
            if (pop && live_q[head_q]) begin
                WrEn = 1'b1;
                Rw   = rw_q[head_q];
                busW = data_q[head_q];
            end
        end
    end

    always_comb begin
        rw_d    = rw_q;
        data_d  = data_q;
        live_d  = live_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (wb_grant && (rw_q[i] == Wb_rw)) live_d[i] = 1'b0;
        end
        if (pop) live_d[head_q] = 1'b0;
        if (push_e) begin
            rw_d[tail_q]   = Md_rw;
            data_d[tail_q] = Md_data;
            live_d[tail_q] = 1'b1;
        end
        head_d  = head_q + AW'(pop);
        tail_d  = tail_q + AW'(push_e);
        count_d = count_q + CW'(push_e) - CW'(pop);
        rdy_d   = 1'b1;
    end

    always_comb begin
        haz_a = 1'b0;
        haz_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i] && (rw_q[i] == Ra)) haz_a = 1'b1;
            if (live_q[i] && (rw_q[i] == Rb)) haz_b = 1'b1;
        end
        Hazard_A = Rst_n && haz_a && (Ra != 5'd0);
        Hazard_B = Rst_n && haz_b && (Rb != 5'd0);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rw_q[i]   <= 5'd0;
                data_q[i] <= 32'd0;
            end
            live_q   <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            starve_q <= 4'd0;
            rdy_q    <= 1'b0;
        end else begin
            rw_q     <= rw_d;
            data_q   <= data_d;
            live_q   <= live_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            rdy_q    <= rdy_d;
        end
    end

endmodule

// File: tb/tb_rf_wport_arb.sv
// Bench for rf_wport_arb: expected register-file writes are queued as stimulus is
// driven and matched against every WrEn seen at the write negedge.
module tb_rf_wport_arb;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Wb_we;
    logic [4:0]  Wb_rw;
    logic [31:0] Wb_data;
    logic        Md_valid;
    logic        Md_ready;
    logic [4:0]  Md_rw;
    logic [31:0] Md_data;
    logic        WrEn;
    logic [4:0]  Rw;
    logic [31:0] busW;
    logic        Stall_wb;
    logic [4:0]  Ra, Rb;
    logic        Hazard_A, Hazard_B;

    logic [36:0] exp_q[$];
    logic [31:0] shadow [32];
    int n_chk  = 0;
    int n_pass = 0;
    int k;

    rf_wport_arb #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Wb_we(Wb_we), .Wb_rw(Wb_rw), .Wb_data(Wb_data),
        .Md_valid(Md_valid), .Md_ready(Md_ready), .Md_rw(Md_rw), .Md_data(Md_data),
        .WrEn(WrEn), .Rw(Rw), .busW(busW), .Stall_wb(Stall_wb),
        .Ra(Ra), .Rb(Rb), .Hazard_A(Hazard_A), .Hazard_B(Hazard_B)
    );

    always #5 Clk = ~Clk;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_chk++;
        if (got === exp_v) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp_v, $time);
    endtask

    task automatic exp_wr(input logic [4:0] rw, input logic [31:0] d);
        exp_q.push_back({rw, d});
    endtask

    task automatic idle_in();
        Wb_we = 1'b0; Wb_rw = 5'd0; Wb_data = 32'd0;
        Md_valid = 1'b0; Md_rw = 5'd0; Md_data = 32'd0;
    endtask

    task automatic next_cyc();
        @(posedge Clk);
        #1;
    endtask

    // Write monitor: each register-file write must be the oldest outstanding expectation.
    always @(negedge Clk) begin
        logic [36:0] e;
        if (WrEn === 1'b1) begin
            shadow[Rw] = busW;
            if (exp_q.size() == 0) begin
                chk_val("unexpected_write", {31'd0, WrEn}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk_val("wr_rw", {27'd0, Rw}, {27'd0, e[36:32]});
                chk_val("wr_data", busW, e[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) shadow[i] = 32'd0;
        idle_in();
        Ra = 5'd0; Rb = 5'd0;

        // Reset holds outputs low even with a WB request present.
        Rst_n = 1'b0;
        Wb_we = 1'b1; Wb_rw = 5'd3; Wb_data = 32'hDEAD;
        @(negedge Clk);
        chk_val("rst_wren", {31'd0, WrEn}, 32'd0);
        chk_val("rst_rw", {27'd0, Rw}, 32'd0);
        chk_val("rst_busw", busW, 32'd0);
        chk_val("rst_ready", {31'd0, Md_ready}, 32'd0);
        chk_val("rst_stall", {31'd0, Stall_wb}, 32'd0);
        next_cyc();
        idle_in();
        Rst_n = 1'b1;
        @(negedge Clk);
        chk_val("rel_ready_pre", {31'd0, Md_ready}, 32'd0);
        next_cyc();
        @(negedge Clk);
        chk_val("rel_ready_post", {31'd0, Md_ready}, 32'd1);
        chk_val("idle_wren", {31'd0, WrEn}, 32'd0);
        chk_val("idle_haz", {30'd0, Hazard_A, Hazard_B}, 32'd0);
        next_cyc();

        // MD alone: written the cycle after acceptance, hazard visible while buffered.
        Ra = 5'd5;
        Md_valid = 1'b1; Md_rw = 5'd5; Md_data = 32'h1234;
        @(negedge Clk);
        chk_val("md_nobypass", {31'd0, WrEn}, 32'd0);
        chk_val("md_haz_pre", {31'd0, Hazard_A}, 32'd0);
        next_cyc();
        idle_in();
        exp_wr(5'd5, 32'h1234);
        @(negedge Clk);
        chk_val("md_haz_buf", {31'd0, Hazard_A}, 32'd1);
        next_cyc();
        @(negedge Clk);
        chk_val("md_haz_post", {31'd0, Hazard_A}, 32'd0);
        chk_val("md_q_empty", exp_q.size(), 32'd0);
        next_cyc();

        // Contention: WB wins four cycles, then one stall cycle drains the MD result.
        k = 0;
        for (int c = 0; c < 8; c++) begin
            Wb_we = 1'b1; Wb_rw = 5'd3; Wb_data = 32'h100 + k;
            Md_valid = (c == 0); Md_rw = 5'd7; Md_data = 32'hAA;
            if (c == 5) exp_wr(5'd7, 32'hAA);
            else exp_wr(5'd3, 32'h100 + k);
            @(negedge Clk);
            chk_val($sformatf("cont_stall_c%0d", c), {31'd0, Stall_wb}, {31'd0, c == 5});
            if (c != 5) k++;
            next_cyc();
        end
        idle_in();
        @(negedge Clk);
        chk_val("cont_q_empty", exp_q.size(), 32'd0);
        next_cyc();

        // Full FIFO: third result waits for a pop; order 1, 2, then 4 preserved.
        k = 0;
        Ra = 5'd2; Rb = 5'd4;
        for (int c = 0; c < 10; c++) begin
            Wb_we = (c <= 6); Wb_rw = 5'd3; Wb_data = 32'h200 + k;
            Md_valid = (c <= 6);
            Md_rw   = (c == 0) ? 5'd1 : (c == 1) ? 5'd2 : 5'd4;
            Md_data = (c == 0) ? 32'd1 : (c == 1) ? 32'd2 : 32'd3;
            if (c <= 4 || c == 6) exp_wr(5'd3, 32'h200 + k);
            else if (c == 5) exp_wr(5'd1, 32'd1);
            else if (c == 7) exp_wr(5'd2, 32'd2);
            else if (c == 8) exp_wr(5'd4, 32'd3);
            @(negedge Clk);
            if (c <= 6)
                chk_val($sformatf("full_ready_c%0d", c), {31'd0, Md_ready},
                        {31'd0, (c <= 1) || (c == 6)});
            chk_val($sformatf("full_stall_c%0d", c), {31'd0, Stall_wb}, {31'd0, c == 5});
            chk_val($sformatf("full_haza_c%0d", c), {31'd0, Hazard_A},
                    {31'd0, (c >= 2) && (c <= 7)});
            chk_val($sformatf("full_hazb_c%0d", c), {31'd0, Hazard_B},
                    {31'd0, (c >= 7) && (c <= 8)});
            if (c <= 6 && c != 5) k++;
            next_cyc();
        end
        idle_in();
        chk_val("full_q_empty", exp_q.size(), 32'd0);

        // Ordering kill: a newer WB write to r9 drops the buffered r9 result.
        Ra = 5'd9; Rb = 5'd0;
        Wb_we = 1'b1; Wb_rw = 5'd3; Wb_data = 32'h300;
        Md_valid = 1'b1; Md_rw = 5'd9; Md_data = 32'h11;
        exp_wr(5'd3, 32'h300);
        @(negedge Clk);
        chk_val("kill_haz_c0", {31'd0, Hazard_A}, 32'd0);
        next_cyc();
        Md_valid = 1'b0;
        Wb_rw = 5'd9; Wb_data = 32'h22;
        exp_wr(5'd9, 32'h22);
        next_cyc();
        idle_in();
        @(negedge Clk);
        chk_val("kill_drop_wren", {31'd0, WrEn}, 32'd0);
        chk_val("kill_haz_c2", {31'd0, Hazard_A}, 32'd0);
        next_cyc();
        @(negedge Clk);
        chk_val("kill_r9", shadow[9], 32'h22);
        chk_val("kill_ready", {31'd0, Md_ready}, 32'd1);
        next_cyc();
        // Same-cycle push and WB write to r9: the pushed result survives and lands later.
        Wb_we = 1'b1; Wb_rw = 5'd9; Wb_data = 32'h44;
        Md_valid = 1'b1; Md_rw = 5'd9; Md_data = 32'h33;
        exp_wr(5'd9, 32'h44);
        next_cyc();
        idle_in();
        exp_wr(5'd9, 32'h33);
        @(negedge Clk);
        chk_val("same_cyc_haz", {31'd0, Hazard_A}, 32'd1);
        next_cyc();
        @(negedge Clk);
        chk_val("same_cyc_r9", shadow[9], 32'h33);
        chk_val("same_cyc_q_empty", exp_q.size(), 32'd0);
        next_cyc();

        // R0 requests: nothing written, nothing buffered, nothing counted.
        Ra = 5'd0;
        for (int c = 0; c < 3; c++) begin
            Wb_we = 1'b1; Wb_rw = 5'd0; Wb_data = 32'hBAD0 + c;
            Md_valid = 1'b1; Md_rw = 5'd0; Md_data = 32'hBAD8;
            @(negedge Clk);
            chk_val($sformatf("r0_wren_c%0d", c), {31'd0, WrEn}, 32'd0);
            chk_val($sformatf("r0_ready_c%0d", c), {31'd0, Md_ready}, 32'd1);
            chk_val($sformatf("r0_haz_c%0d", c), {31'd0, Hazard_A}, 32'd0);
            next_cyc();
        end
        Md_rw = 5'd8; Md_data = 32'h88;
        next_cyc();
        Md_valid = 1'b0;
        exp_wr(5'd8, 32'h88);
        @(negedge Clk);
        chk_val("r0_wb_no_stall", {31'd0, Stall_wb}, 32'd0);
        next_cyc();
        idle_in();

        // Reset mid-operation discards the buffered result.
        Ra = 5'd6;
        Wb_we = 1'b1; Wb_rw = 5'd3; Wb_data = 32'h500;
        Md_valid = 1'b1; Md_rw = 5'd6; Md_data = 32'h66;
        exp_wr(5'd3, 32'h500);
        next_cyc();
        Md_valid = 1'b0; Wb_data = 32'h501;
        exp_wr(5'd3, 32'h501);
        @(negedge Clk);
        chk_val("mid_haz_pre", {31'd0, Hazard_A}, 32'd1);
        next_cyc();
        Rst_n = 1'b0;
        @(negedge Clk);
        chk_val("mid_rst_wren", {31'd0, WrEn}, 32'd0);
        chk_val("mid_rst_busw", busW, 32'd0);
        chk_val("mid_rst_ready", {31'd0, Md_ready}, 32'd0);
        chk_val("mid_rst_haz", {31'd0, Hazard_A}, 32'd0);
        next_cyc();
        idle_in();
        Rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge Clk);
            chk_val($sformatf("mid_post_wren_c%0d", c), {31'd0, WrEn}, 32'd0);
            chk_val($sformatf("mid_post_haz_c%0d", c), {31'd0, Hazard_A}, 32'd0);
            next_cyc();
        end
        chk_val("final_q_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
